machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer_pkg.sv | 19 +
 rtl/mtime_counter.sv | 52 +++++
 rtl/machine_timer.sv | 137 +++++++++++++
 tb/tb_machine_timer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL field
// positions and the bus handshake state encoding.
package machine_timer_pkg;

  localparam logic [4:0] ADDR_MTIME_LO    = 5'h00;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] ADDR_CTRL        = 5'h10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/mtime_counter.sv
// Prescaled 64-bit mtime counter. A bus load of either half suppresses the
// tick increment for that edge so the written value lands exactly.
module mtime_counter #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr_presc,
  input  logic               load_lo,
  input  logic               load_hi,
  input  logic [31:0]        wdata,
  output logic [63:0]        mtime
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [63:0]        mtime_q, mtime_d;
  logic               tick;

  always_comb begin
    tick  = en && (cnt_q == presc);
    cnt_d = cnt_q;
    if (clr_presc || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end

    mtime_d = mtime_q;
    if (load_lo) begin
      mtime_d[31:0] = wdata;
    end else if (load_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mtime_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V style machine timer: register bus FSM, mtimecmp,
// CTRL and the registered level interrupt compare.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tm_interrupt
);

  bus_state_e         state_q, state_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        snap_q, snap_d;
  logic               irq_q;

  logic [63:0] mtime;
  logic        accept, wr_en, rd_en, mapped;
  logic        load_lo, load_hi, ctrl_wr;
  logic [31:0] ctrl_word, rd_data;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign wr_en   = accept && req_we;
  assign rd_en   = accept && !req_we;
  assign mapped  = req_addr inside {ADDR_MTIME_LO, ADDR_MTIME_HI, ADDR_MTIMECMP_LO,
                                    ADDR_MTIMECMP_HI, ADDR_CTRL};
  assign load_lo = wr_en && (req_addr == ADDR_MTIME_LO);
  assign load_hi = wr_en && (req_addr == ADDR_MTIME_HI);
  assign ctrl_wr = wr_en && (req_addr == ADDR_CTRL);

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = en_q;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
  end

  // MTIME_HI reads the snapshot taken by the last MTIME_LO read.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      ADDR_MTIME_LO:    rd_data = mtime[31:0];
      ADDR_MTIME_HI:    rd_data = snap_q;
      ADDR_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
      ADDR_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
      ADDR_CTRL:        rd_data = ctrl_word;
      default:          rd_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_RESP;
          rsp_rdata_d = req_we ? 32'd0 : rd_data;
          rsp_err_d   = !mapped;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    presc_d    = presc_q;
    snap_d     = snap_q;
    if (wr_en && req_addr == ADDR_MTIMECMP_LO) mtimecmp_d[31:0]  = req_wdata;
    if (wr_en && req_addr == ADDR_MTIMECMP_HI) mtimecmp_d[63:32] = req_wdata;
    if (ctrl_wr) begin
      en_d    = req_wdata[CTRL_EN_BIT];
      presc_d = req_wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
    if (rd_en && req_addr == ADDR_MTIME_LO) snap_d = mtime[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mtimecmp_q  <= '1;
      en_q        <= 1'b0;
      presc_q     <= '0;
      snap_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      presc_q     <= presc_d;
      snap_q      <= snap_d;
      irq_q       <= (mtime >= mtimecmp_q);
    end
  end

  mtime_counter #(.PRESC_W(PRESC_W)) u_mtime_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (en_q),
    .presc     (presc_q),
    .clr_presc (ctrl_wr),
    .load_lo   (load_lo),
    .load_hi   (load_hi),
    .wdata     (req_wdata),
    .mtime     (mtime)
  );

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign tm_interrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: directed scenarios plus randomized register traffic
// checked against an arithmetic model of mtime (ticks counted from edge numbers).
module tb_machine_timer;

  localparam logic [4:0] A_LO    = 5'h00;
  localparam logic [4:0] A_HI    = 5'h04;
  localparam logic [4:0] A_CMPLO = 5'h08;
  localparam logic [4:0] A_CMPHI = 5'h0C;
  localparam logic [4:0] A_CTRL  = 5'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tm_interrupt;

  int total = 0;
  int bad = 0;
  int proto_bad = 0;
  int cyc = 0;

  // Model: mtime after edge k is m_base plus the ticks that fall in (m_kb, k];
  // with prescale P ticks land on edges m_k0 + j*(P+1), j >= 1.
  logic [63:0] m_base, m_cmp;
  logic [31:0] m_snap;
  int          m_kb, m_k0, m_presc;
  bit          m_en;

  machine_timer #(.PRESC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .tm_interrupt (tm_interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mt_at(input int k);
    longint t;
    if (!m_en) return m_base;
    t = longint'((k - m_k0) / (m_presc + 1) - (m_kb - m_k0) / (m_presc + 1));
    return m_base + 64'(t);
  endfunction

  function automatic logic exp_irq();
    logic [63:0] v;
    v = mt_at(cyc - 1);
    return (v >= m_cmp);
  endfunction

  task automatic model_reset();
    m_base = '0; m_cmp = '1; m_snap = '0;
    m_kb = 0; m_k0 = 0; m_presc = 0; m_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One full handshake starting and ending on a falling edge.
  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err, output int ka,
                     output logic ok);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 20);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    ka = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    ok = ok && (rsp_valid === 1'b1);
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    $display("xact we=%0d addr=%h wdata=%h rdata=%h err=%b edge=%0d", we, a, d, rdata, err, ka);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r; logic e, ok; int ka; logic [63:0] v;
    bus(1'b1, a, d, r, e, ka, ok);
    if (!ok) proto_bad++;
    case (a)
      A_LO:    begin v = mt_at(ka - 1); m_base = {v[63:32], d}; m_kb = ka; end
      A_HI:    begin v = mt_at(ka - 1); m_base = {d, v[31:0]}; m_kb = ka; end
      A_CMPLO: m_cmp[31:0] = d;
      A_CMPHI: m_cmp[63:32] = d;
      A_CTRL:  begin
        v = mt_at(ka); m_base = v; m_kb = ka; m_k0 = ka;
        m_en = d[0]; m_presc = int'(d[15:8]);
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] got, output logic [31:0] exp,
                    output logic gerr, output logic eerr);
    logic ok; int ka; logic [63:0] v;
    bus(1'b0, a, 32'd0, got, gerr, ka, ok);
    if (!ok) proto_bad++;
    v = mt_at(ka - 1);
    eerr = 1'b0;
    case (a)
      A_LO:    begin exp = v[31:0]; m_snap = v[63:32]; end
      A_HI:    exp = m_snap;
      A_CMPLO: exp = m_cmp[31:0];
      A_CMPHI: exp = m_cmp[63:32];
      A_CTRL:  exp = {16'd0, 8'(m_presc), 7'd0, m_en};
      default: begin exp = 32'd0; eerr = 1'b1; end
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] g, e; logic ge, ee; bit seen = 0;
    proto_bad = 0;
    do_reset();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
        rsp_err !== 1'b0 || tm_interrupt !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b irq=%b want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, tm_interrupt);
    end
    rd(A_CTRL, g, e, ge, ee);
    total++;
    if (g !== e || ge !== ee) begin
      bad++; $display("FAIL reset_ctrl: got=%h err=%b want=%h err=%b", g, ge, e, ee);
    end
    for (int i = 0; i < 1000; i++) begin
      if (tm_interrupt !== 1'b0) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_irq_quiet: irq seen=1 want 0"); end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL reset_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_irq_rise();
    int k10 = -1, rise = -1;
    logic [63:0] v;
    proto_bad = 0;
    do_reset();
    wr(A_CMPHI, 32'd0);
    wr(A_CMPLO, 32'd10);
    wr(A_CTRL, 32'h1);
    for (int k = m_kb; k < m_kb + 100; k++) begin
      v = mt_at(k);
      if (v >= 64'd10) begin k10 = k; break; end
    end
    for (int i = 0; i < 60; i++) begin
      if (tm_interrupt === 1'b1) begin rise = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (rise !== k10 + 1) begin
      bad++; $display("FAIL irq_rise_edge: got=%0d want=%0d", rise, k10 + 1);
    end
    repeat (5) @(negedge clk);
    total++;
    if (tm_interrupt !== 1'b1) begin bad++; $display("FAIL irq_level_hold: got=%b want 1", tm_interrupt); end
    wr(A_CMPLO, 32'd100000);
    total++;
    if (tm_interrupt !== exp_irq()) begin
      bad++; $display("FAIL irq_clear_on_cmp_raise: got=%b want=%b", tm_interrupt, exp_irq());
    end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL irq_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_prescale();
    logic [31:0] g, e; logic ge, ee;
    proto_bad = 0;
    do_reset();
    wr(A_CTRL, 32'h0301);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 15)) @(negedge clk);
      rd(A_LO, g, e, ge, ee);
      total++;
      if (g !== e) begin bad++; $display("FAIL presc3_lo[%0d]: got=%h want=%h", i, g, e); end
    end
    wr(A_CTRL, 32'h0300);
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(5, 20)) @(negedge clk);
      rd(A_LO, g, e, ge, ee);
      total++;
      if (g !== e) begin bad++; $display("FAIL presc_frozen_lo[%0d]: got=%h want=%h", i, g, e); end
    end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL presc_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_wrap_snapshot();
    logic [31:0] g, e; logic ge, ee;
    proto_bad = 0;
    do_reset();
    wr(A_HI, 32'hFFFF_FFFF);
    wr(A_LO, 32'hFFFF_FFFE);
    // Enable then disable back-to-back: two ticks carry mtime through the wrap.
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    rd(A_LO, g, e, ge, ee);
    total++;
    if (g !== e || g !== 32'd0) begin bad++; $display("FAIL wrap_lo: got=%h want=%h", g, e); end
    rd(A_HI, g, e, ge, ee);
    total++;
    if (g !== e || g !== 32'd0) begin bad++; $display("FAIL wrap_hi: got=%h want=%h", g, e); end
    wr(A_HI, 32'd5);
    wr(A_LO, 32'hFFFF_FFF0);
    wr(A_CTRL, 32'h1);
    rd(A_LO, g, e, ge, ee);
    total++;
    if (g !== e) begin bad++; $display("FAIL snap_lo: got=%h want=%h", g, e); end
    repeat (25) @(negedge clk);
    rd(A_HI, g, e, ge, ee);
    total++;
    if (g !== e) begin bad++; $display("FAIL snap_hi_consistent: got=%h want=%h", g, e); end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL wrap_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_backpressure();
    logic [31:0] v, g, e, r; logic ge, ee, er, ok; int ka; bit stable_ok = 1;
    proto_bad = 0;
    do_reset();
    v = $urandom;
    wr(A_CMPLO, v);
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMPLO;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== v || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        stable_ok = 0;
        $display("FAIL hold_cycle[%0d]: valid=%b rdata=%h err=%b ready=%b want 1 %h 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, v);
      end
    end
    total++;
    if (!stable_ok) bad++;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    rd(5'h14, g, e, ge, ee);
    total++;
    if (g !== 32'd0 || ge !== 1'b1) begin bad++; $display("FAIL unmapped_read: got=%h err=%b want 0 1", g, ge); end
    bus(1'b1, 5'h14, 32'h0000_0301, r, er, ka, ok);
    total++;
    if (!ok || r !== 32'd0 || er !== 1'b1) begin
      bad++; $display("FAIL unmapped_write: ok=%b rdata=%h err=%b want 1 0 1", ok, r, er);
    end
    bus(1'b1, A_CMPHI, 32'h1234_5678, r, er, ka, ok);
    m_cmp[63:32] = 32'h1234_5678;
    total++;
    if (!ok || r !== 32'd0 || er !== 1'b0) begin
      bad++; $display("FAIL mapped_write_rsp: ok=%b rdata=%h err=%b want 1 0 0", ok, r, er);
    end
    rd(A_CTRL, g, e, ge, ee);
    total++;
    if (g !== e || ge !== ee) begin bad++; $display("FAIL ctrl_untouched: got=%h want=%h", g, e); end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL bp_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] g, e; logic ge, ee;
    proto_bad = 0;
    do_reset();
    wr(A_CMPLO, 32'hA5A5_0000);
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMPLO;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_in_resp: valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                      rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    rd(A_CMPLO, g, e, ge, ee);
    total++;
    if (g !== e) begin bad++; $display("FAIL cmp_after_reset: got=%h want=%h", g, e); end
    // PRESC=0: every edge ticks, so each mtime write collides with a tick.
    wr(A_CTRL, 32'h1);
    wr(A_LO, $urandom);
    wr(A_HI, $urandom_range(0, 255));
    rd(A_LO, g, e, ge, ee);
    total++;
    if (g !== e) begin bad++; $display("FAIL tick_write_lo: got=%h want=%h", g, e); end
    rd(A_HI, g, e, ge, ee);
    total++;
    if (g !== e) begin bad++; $display("FAIL tick_write_hi: got=%h want=%h", g, e); end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL rir_proto: errors=%0d want 0", proto_bad); end
  endtask

  task automatic test_random();
    logic [31:0] g, e, ctrl; logic ge, ee, xi;
    proto_bad = 0;
    do_reset();
    for (int it = 0; it < 16; it++) begin
      ctrl = (32'($urandom_range(0, 5)) << 8) | 32'($urandom_range(0, 1));
      wr(A_CMPLO, $urandom);
      wr(A_CMPHI, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) wr(A_HI, $urandom_range(0, 2));
      wr(A_LO, $urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF - $urandom_range(0, 6) : $urandom);
      wr(A_CTRL, ctrl);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      rd(A_LO, g, e, ge, ee);
      total++;
      if (g !== e) begin bad++; $display("FAIL rand_lo[%0d]: got=%h want=%h", it, g, e); end
      rd(A_HI, g, e, ge, ee);
      total++;
      if (g !== e) begin bad++; $display("FAIL rand_hi[%0d]: got=%h want=%h", it, g, e); end
      xi = exp_irq();
      total++;
      if (tm_interrupt !== xi) begin bad++; $display("FAIL rand_irq[%0d]: got=%b want=%b", it, tm_interrupt, xi); end
    end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL rand_proto: errors=%0d want 0", proto_bad); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_irq_rise();
    test_prescale();
    test_wrap_snapshot();
    test_backpressure();
    test_reset_in_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
